// File: rtl/bottling_controller.sv
// -----------------------------------------------------------------------------
// bottling_controller
//
// Sequences the pill-bottling datapath. It gates the pill generator through
// pill_disable and counts pills into the current bottle. When a bottle is
// full it runs a timed bottle swap. It stops once the configured number of
// bottles has been filled.
//
// Parameters
//   PILL_W       width of the pills-per-bottle setting and pill counter
//   BOTTLE_W     width of the bottle target and bottle counter
//   SWAP_CYCLES  clock cycles a bottle swap lasts (>= 1)
//
// Ports
//   clock                 in   system clock
//   reset                 in   asynchronous, active-high reset
//   start                 in   rising edge launches a run and latches config
//   pause                 in   level; holds filling while high
//   cfg_pills_per_bottle  in   pills per bottle
//   cfg_bottle_target     in   bottles per run
//   pill_pulse            in   pill generator output, one pill per rising edge
//   pill_disable          out  low only while filling
//   bottle_swap           out  high throughout the swap phase
//   pill_count            out  pills in the current bottle
//   bottle_count          out  bottles completed
//   spill_count           out  pills seen outside FILL, saturates at 255
//   busy                  out  high in FILL, SWAP and PAUSED
//   done                  out  high in DONE
//   config_error          out  set when a start is rejected
//   state_dbg             out  current FSM state (IDLE=0 FILL=1 SWAP=2
//                              PAUSED=3 DONE=4)
// -----------------------------------------------------------------------------
module bottling_controller #(
   parameter int PILL_W      = 8,
   parameter int BOTTLE_W    = 8,
   parameter int SWAP_CYCLES = 50000000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                pause,
   input  logic [PILL_W-1:0]   cfg_pills_per_bottle,
   input  logic [BOTTLE_W-1:0] cfg_bottle_target,
   input  logic                pill_pulse,
   output logic                pill_disable,
   output logic                bottle_swap,
   output logic [PILL_W-1:0]   pill_count,
   output logic [BOTTLE_W-1:0] bottle_count,
   output logic [7:0]          spill_count,
   output logic                busy,
   output logic                done,
   output logic                config_error,
   output logic [2:0]          state_dbg
);

   localparam int TMR_W = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;
   localparam logic [TMR_W-1:0] SWAP_LOAD = TMR_W'(SWAP_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FILL   = 3'd1,
      ST_SWAP   = 3'd2,
      ST_PAUSED = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t              state_q, state_d;

   // Input registers. The edge detectors look at the registered copy and at
   // its one-cycle-older value, so an event is seen one cycle after the
   // input rises.
   logic                start_in_q, start_prev_q;
   logic                pill_in_q, pill_prev_q;
   logic                start_evt, pill_evt;

   logic [PILL_W-1:0]   ppb_q, ppb_d;
   logic [BOTTLE_W-1:0] target_q, target_d;
   logic [PILL_W-1:0]   pill_count_q, pill_count_d;
   logic [BOTTLE_W-1:0] bottle_count_q, bottle_count_d;
   logic [7:0]          spill_count_q, spill_count_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic                config_error_q, config_error_d;
   logic                pill_disable_q, pill_disable_d;
   logic                bottle_swap_q, bottle_swap_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [PILL_W-1:0]   pill_inc;
   logic [BOTTLE_W-1:0] bottle_inc;
   logic                completing;

   assign start_evt  = start_in_q & ~start_prev_q;
   assign pill_evt   = pill_in_q & ~pill_prev_q;
   assign pill_inc   = pill_count_q + PILL_W'(1);
   assign bottle_inc = bottle_count_q + BOTTLE_W'(1);

   // ---------------------------------------------------------------------
   // Next-state and datapath
   // ---------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      ppb_d          = ppb_q;
      target_d       = target_q;
      pill_count_d   = pill_count_q;
      bottle_count_d = bottle_count_q;
      spill_count_d  = spill_count_q;
      timer_d        = timer_q;
      config_error_d = config_error_q;
      completing     = 1'b0;

      // Leakage from the generator outside FILL. An accepted start in the
      // same cycle clears the counter below and takes precedence.
      if (pill_evt && (state_q != ST_FILL) && (spill_count_q != 8'hFF)) begin
         spill_count_d = spill_count_q + 8'd1;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_evt) begin
               if ((cfg_pills_per_bottle == '0) || (cfg_bottle_target == '0)) begin
                  config_error_d = 1'b1;
               end else begin
                  ppb_d          = cfg_pills_per_bottle;
                  target_d       = cfg_bottle_target;
                  pill_count_d   = '0;
                  bottle_count_d = '0;
                  spill_count_d  = '0;
                  config_error_d = 1'b0;
                  state_d        = ST_FILL;
               end
            end
         end

         ST_FILL: begin
            if (pill_evt) begin
               pill_count_d = pill_inc;
               if (pill_inc == ppb_q) begin
                  completing     = 1'b1;
                  bottle_count_d = bottle_inc;
                  if (bottle_inc == target_q) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_SWAP;
                     timer_d = SWAP_LOAD;
                  end
               end
            end
            // A completing bottle always goes to SWAP/DONE; pause is picked
            // up again at the end of the swap.
            if (!completing && pause) begin
               state_d = ST_PAUSED;
            end
         end

         ST_SWAP: begin
            if (timer_q == '0) begin
               pill_count_d = '0;
               state_d      = pause ? ST_PAUSED : ST_FILL;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end

         ST_PAUSED: begin
            if (!pause) begin
               state_d = ST_FILL;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered copies of the next state's decode.
      pill_disable_d = (state_d != ST_FILL);
      bottle_swap_d  = (state_d == ST_SWAP);
      busy_d         = (state_d == ST_FILL) || (state_d == ST_SWAP) ||
                       (state_d == ST_PAUSED);
      done_d         = (state_d == ST_DONE);
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         start_in_q     <= 1'b0;
         start_prev_q   <= 1'b0;
         pill_in_q      <= 1'b0;
         pill_prev_q    <= 1'b0;
         ppb_q          <= '0;
         target_q       <= '0;
         pill_count_q   <= '0;
         bottle_count_q <= '0;
         spill_count_q  <= '0;
         timer_q        <= '0;
         config_error_q <= 1'b0;
         pill_disable_q <= 1'b1;
         bottle_swap_q  <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         start_in_q     <= start;
         start_prev_q   <= start_in_q;
         pill_in_q      <= pill_pulse;
         pill_prev_q    <= pill_in_q;
         ppb_q          <= ppb_d;
         target_q       <= target_d;
         pill_count_q   <= pill_count_d;
         bottle_count_q <= bottle_count_d;
         spill_count_q  <= spill_count_d;
         timer_q        <= timer_d;
         config_error_q <= config_error_d;
         pill_disable_q <= pill_disable_d;
         bottle_swap_q  <= bottle_swap_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign pill_disable = pill_disable_q;
   assign bottle_swap  = bottle_swap_q;
   assign pill_count   = pill_count_q;
   assign bottle_count = bottle_count_q;
   assign spill_count  = spill_count_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign config_error = config_error_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_bottling_controller.sv
// -----------------------------------------------------------------------------
// tb_bottling_controller
//
// Directed bench for bottling_controller with SWAP_CYCLES = 4. Inputs change
// and outputs are sampled just after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bottling_controller;

   localparam int PILL_W   = 8;
   localparam int BOTTLE_W = 8;
   localparam int SWAP_CYC = 4;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FILL   = 3'd1;
   localparam logic [2:0] S_SWAP   = 3'd2;
   localparam logic [2:0] S_PAUSED = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic                clock;
   logic                reset;
   logic                start;
   logic                pause;
   logic [PILL_W-1:0]   cfg_pills_per_bottle;
   logic [BOTTLE_W-1:0] cfg_bottle_target;
   logic                pill_pulse;
   logic                pill_disable;
   logic                bottle_swap;
   logic [PILL_W-1:0]   pill_count;
   logic [BOTTLE_W-1:0] bottle_count;
   logic [7:0]          spill_count;
   logic                busy;
   logic                done;
   logic                config_error;
   logic [2:0]          state_dbg;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;
   int swap_len;

   logic [PILL_W-1:0] exp_q[$];

   bottling_controller #(
      .PILL_W      (PILL_W),
      .BOTTLE_W    (BOTTLE_W),
      .SWAP_CYCLES (SWAP_CYC)
   ) dut (
      .clock                (clock),
      .reset                (reset),
      .start                (start),
      .pause                (pause),
      .cfg_pills_per_bottle (cfg_pills_per_bottle),
      .cfg_bottle_target    (cfg_bottle_target),
      .pill_pulse           (pill_pulse),
      .pill_disable         (pill_disable),
      .bottle_swap          (bottle_swap),
      .pill_count           (pill_count),
      .bottle_count         (bottle_count),
      .spill_count          (spill_count),
      .busy                 (busy),
      .done                 (done),
      .config_error         (config_error),
      .state_dbg            (state_dbg)
   );

   // Clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timed out");
   end

   task automatic step();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_pill_sb(input string tag);
      logic [PILL_W-1:0] e;
      e = exp_q.pop_front();
      chk(tag, 32'(pill_count), 32'(e));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic do_start(input int ppb, input int tgt);
      cfg_pills_per_bottle = PILL_W'(ppb);
      cfg_bottle_target    = BOTTLE_W'(tgt);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
   endtask

   // One pill: rising edge, then one low cycle. pill_count reflects it on
   // return.
   task automatic do_pill();
      pill_pulse = 1'b1;
      step();
      pill_pulse = 1'b0;
      step();
   endtask

   // Counts samples with bottle_swap high (including the current one) until
   // it drops, bounded.
   task automatic measure_swap(output int len);
      len = 0;
      for (int i = 0; i < 20; i++) begin
         if (!bottle_swap) break;
         len++;
         step();
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      pause = 1'b0;
      pill_pulse = 1'b0;
      cfg_pills_per_bottle = '0;
      cfg_bottle_target = '0;
      step();

      // Reset values
      chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
      chk("rst_pill_disable", 32'(pill_disable), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_swap", 32'(bottle_swap), 32'd0);
      chk("rst_cfg_err", 32'(config_error), 32'd0);
      chk("rst_pill_cnt", 32'(pill_count), 32'd0);
      reset = 1'b0;
      step();

      // Full run: 3 pills x 2 bottles
      exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
      exp_q.push_back(8'd0);
      exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
      do_start(3, 2);
      chk("run_fill", 32'(state_dbg), 32'(S_FILL));
      chk("run_pd_low", 32'(pill_disable), 32'd0);
      chk("run_busy", 32'(busy), 32'd1);
      do_pill(); chk_pill_sb("run_pc_a");
      do_pill(); chk_pill_sb("run_pc_b");
      do_pill(); chk_pill_sb("run_pc_c");
      chk("run_swap_state", 32'(state_dbg), 32'(S_SWAP));
      chk("run_swap_pd", 32'(pill_disable), 32'd1);
      chk("run_bottle1", 32'(bottle_count), 32'd1);
      measure_swap(swap_len);
      chk("run_swap_len", 32'(swap_len), 32'(SWAP_CYC));
      chk_pill_sb("run_pc_cleared");
      chk("run_refill", 32'(state_dbg), 32'(S_FILL));
      chk("run_refill_pd", 32'(pill_disable), 32'd0);
      do_pill(); chk_pill_sb("run_pc_d");
      do_pill(); chk_pill_sb("run_pc_e");
      do_pill(); chk_pill_sb("run_pc_f");
      chk("run_done", 32'(done), 32'd1);
      chk("run_done_state", 32'(state_dbg), 32'(S_DONE));
      chk("run_bottle2", 32'(bottle_count), 32'd2);
      chk("run_end_pd", 32'(pill_disable), 32'd1);
      chk("run_end_busy", 32'(busy), 32'd0);
      chk("run_no_spill", 32'(spill_count), 32'd0);
      chk("run_sb_empty", 32'(exp_q.size()), 32'd0);

      // Rejected start, then a valid 2x1 run
      do_reset();
      do_start(0, 2);
      chk("cfg_err_set", 32'(config_error), 32'd1);
      chk("cfg_err_idle", 32'(state_dbg), 32'(S_IDLE));
      chk("cfg_err_pd", 32'(pill_disable), 32'd1);
      do_start(2, 1);
      chk("cfg_err_clr", 32'(config_error), 32'd0);
      chk("cfg_ok_fill", 32'(state_dbg), 32'(S_FILL));
      do_pill();
      do_pill();
      chk("cfg_ok_done", 32'(done), 32'd1);
      chk("cfg_ok_bottles", 32'(bottle_count), 32'd1);

      // Spill in IDLE and during SWAP
      do_reset();
      do_pill();
      chk("spill_idle", 32'(spill_count), 32'd1);
      chk("spill_idle_pc", 32'(pill_count), 32'd0);
      do_start(3, 2);
      chk("spill_cleared", 32'(spill_count), 32'd0);
      do_pill(); do_pill(); do_pill();
      do_pill();
      chk("spill_in_swap_state", 32'(state_dbg), 32'(S_SWAP));
      chk("spill_swap", 32'(spill_count), 32'd1);
      chk("spill_swap_pc", 32'(pill_count), 32'd3);
      do_reset();
      do_pill();
      chk("spill_idle2", 32'(spill_count), 32'd1);
      for (int i = 0; i < 299; i++) do_pill();
      chk("spill_sat", 32'(spill_count), 32'd255);

      // Pause in the same cycle as a pill event
      do_reset();
      do_start(3, 2);
      pill_pulse = 1'b1;
      step();
      pill_pulse = 1'b0;
      pause = 1'b1;
      step();
      chk("pause_pill_pc", 32'(pill_count), 32'd1);
      chk("pause_state", 32'(state_dbg), 32'(S_PAUSED));
      chk("pause_pd", 32'(pill_disable), 32'd1);
      chk("pause_busy", 32'(busy), 32'd1);
      pause = 1'b0;
      step();
      chk("unpause_fill", 32'(state_dbg), 32'(S_FILL));
      do_pill(); do_pill();
      chk("pause_swap_entry", 32'(state_dbg), 32'(S_SWAP));
      pause = 1'b1;
      measure_swap(swap_len);
      chk("pause_swap_len", 32'(swap_len), 32'(SWAP_CYC));
      chk("pause_after_swap", 32'(state_dbg), 32'(S_PAUSED));
      chk("pause_after_swap_pc", 32'(pill_count), 32'd0);
      pause = 1'b0;
      step();
      chk("release_fill", 32'(state_dbg), 32'(S_FILL));

      // Pause on the completing cycle: swap taken, not stretched
      do_reset();
      do_start(2, 3);
      do_pill();
      pill_pulse = 1'b1;
      step();
      pill_pulse = 1'b0;
      pause = 1'b1;
      step();
      chk("pcomp_swap", 32'(state_dbg), 32'(S_SWAP));
      chk("pcomp_pc", 32'(pill_count), 32'd2);
      chk("pcomp_bottle", 32'(bottle_count), 32'd1);
      measure_swap(swap_len);
      chk("pcomp_swap_len", 32'(swap_len), 32'(SWAP_CYC));
      chk("pcomp_paused", 32'(state_dbg), 32'(S_PAUSED));
      pause = 1'b0;
      step();

      // Second start ignored in FILL, then asynchronous reset mid-FILL
      do_reset();
      do_start(3, 2);
      do_pill(); do_pill();
      do_start(1, 1);
      chk("restart_ignored", 32'(state_dbg), 32'(S_FILL));
      chk("restart_pc", 32'(pill_count), 32'd2);
      chk("restart_bottle", 32'(bottle_count), 32'd0);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_state", 32'(state_dbg), 32'(S_IDLE));
      chk("arst_pc", 32'(pill_count), 32'd0);
      chk("arst_pd", 32'(pill_disable), 32'd1);
      chk("arst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      step();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
